// File: rtl/evg_dbus_generator.sv
// evg_dbus_generator: distributed-bus word builder for one event generator.
// Bit 0 carries the heartbeat; bits 1..CHANNEL_COUNT are programmable divider/one-shot/passthrough channels.
module evg_dbus_generator #(
    parameter int TXCLK_NOMINAL_FREQUENCY = 125000000,
    parameter int DISTRIBUTED_BUS_WIDTH   = 8,
    parameter int CHANNEL_COUNT           = 4,
    parameter int DIVIDER_WIDTH           = 16,
    localparam int CW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic                             evgTxClk,
    input  logic                             evgTxRst_n,
    input  logic                             evgHeartbeatRequest,
    input  logic                             evgCfgStrobe,
    input  logic [CW-1:0]                    evgCfgChannel,
    input  logic [1:0]                       evgCfgSelect,
    input  logic [DIVIDER_WIDTH-1:0]         evgCfgData,
    input  logic [CHANNEL_COUNT-1:0]         evgExternal,
    output logic [DISTRIBUTED_BUS_WIDTH-1:0] evgDistributedBus,
    output logic [CHANNEL_COUNT-1:0]         evgChannelActive
);
    localparam logic [DIVIDER_WIDTH-1:0] CH0_PERIOD = DIVIDER_WIDTH'(TXCLK_NOMINAL_FREQUENCY / 100000 - 1);

    logic                             hb_q;
    logic [CHANNEL_COUNT-1:0]         out_d;
    logic [CHANNEL_COUNT-1:0]         act_d;
    logic [CHANNEL_COUNT-1:0]         act_q;
    logic [DISTRIBUTED_BUS_WIDTH-1:0] bus_q;
    logic                             unused_cfg;

    assign unused_cfg = ^evgCfgData[DIVIDER_WIDTH-1:4];

    for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : g_ch
        logic                     en_q;
        logic                     rs_q;
        logic                     run_q;
        logic                     run_d;
        logic                     wr;
        logic                     ch_out;
        logic                     ch_act;
        logic [1:0]               mode_q;
        logic [DIVIDER_WIDTH-1:0] per_q;
        logic [DIVIDER_WIDTH-1:0] high_q;
        logic [DIVIDER_WIDTH-1:0] ph_q;
        logic [DIVIDER_WIDTH-1:0] ph_d;
        logic [DIVIDER_WIDTH:0]   ph_inc;

        assign wr = evgCfgStrobe && (int'(evgCfgChannel) == k);

        // Next state uses the pre-write config so a coinciding write never alters this edge's heartbeat decision.
        always_comb begin
            ph_inc = {1'b0, ph_q} + 1'b1;
            ph_d   = '0;
            run_d  = 1'b0;
            if (en_q && mode_q == 2'd0) begin
                ph_d = ((rs_q && evgHeartbeatRequest) || ph_q >= per_q) ? '0 : ph_inc[DIVIDER_WIDTH-1:0];
            end else if (en_q && mode_q == 2'd1) begin
                run_d = evgHeartbeatRequest || (run_q && ph_inc < {1'b0, high_q});
                ph_d  = (!evgHeartbeatRequest && run_d) ? ph_inc[DIVIDER_WIDTH-1:0] : '0;
            end
            ch_out = en_q && (mode_q == 2'd0 ? ph_q < high_q :
                              mode_q == 2'd1 ? run_q && ph_q < high_q :
                              mode_q == 2'd2 ? evgExternal[k] : 1'b0);
            ch_act = en_q && mode_q != 2'd3 && (mode_q != 2'd1 || run_q);
        end

        always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
            if (!evgTxRst_n) begin
                en_q   <= 1'(k == 0);
                rs_q   <= 1'b0;
                mode_q <= '0;
                per_q  <= (k == 0) ? CH0_PERIOD : '0;
                high_q <= (k == 0) ? DIVIDER_WIDTH'(1) : '0;
                ph_q   <= '0;
                run_q  <= 1'b0;
            end else begin
                ph_q  <= ph_d;
                run_q <= run_d;
                if (wr && evgCfgSelect == 2'd0) per_q <= evgCfgData;
                if (wr && evgCfgSelect == 2'd1) high_q <= evgCfgData;
                if (wr && evgCfgSelect == 2'd2) {rs_q, mode_q, en_q} <= evgCfgData[3:0];
            end
        end

        assign out_d[k] = ch_out;
        assign act_d[k] = ch_act;
    end

    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            hb_q  <= 1'b0;
            bus_q <= '0;
            act_q <= '0;
        end else begin
            hb_q  <= evgHeartbeatRequest;
            bus_q <= DISTRIBUTED_BUS_WIDTH'({out_d, hb_q});
            act_q <= act_d;
        end
    end

    assign evgDistributedBus = bus_q;
    assign evgChannelActive  = act_q;
endmodule

// File: tb/tb_evg_dbus_generator.sv
// tb_evg_dbus_generator: scoreboard bench for the distributed-bus generator.
// Expectations are queued as stimulus is driven and compared when the bus cycle they describe arrives.
module tb_evg_dbus_generator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hb = 1'b0;
    logic        strobe = 1'b0;
    logic [1:0]  ch = '0;
    logic [1:0]  sel = '0;
    logic [15:0] data = '0;
    logic [3:0]  ext = '0;
    logic [7:0]  bus;
    logic [3:0]  act;
    logic [11:0] obs;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          due;
        logic [11:0] mask;
        logic [11:0] val;
    } exp_t;
    exp_t sb[$];

    assign obs = {act, bus};

    always #5 clk = ~clk;

    evg_dbus_generator dut (
        .evgTxClk            (clk),
        .evgTxRst_n          (rst_n),
        .evgHeartbeatRequest (hb),
        .evgCfgStrobe        (strobe),
        .evgCfgChannel       (ch),
        .evgCfgSelect        (sel),
        .evgCfgData          (data),
        .evgExternal         (ext),
        .evgDistributedBus   (bus),
        .evgChannelActive    (act)
    );

    task automatic cfg(input int c, input int s, input int d);
        @(negedge clk);
        strobe = 1'b1;
        ch     = c[1:0];
        sel    = s[1:0];
        data   = d[15:0];
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 000", obs);
        end
        rst_n = 1'b1;
        sb.delete();
        for (int j = 0; j < 1300; j++) sb.push_back('{j, 12'hfff, (j == 0 || j == 1250) ? 12'h102 : 12'h100});
        for (int j = 0; j < 1300; j++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == j) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.mask) !== e.val) begin
                    errors++;
                    $display("FAIL reset_default step %0d: got %h expected %h", j, obs & e.mask, e.val);
                end
            end
        end
    endtask

    task automatic test_heartbeat(input logic [15:0] pat, input string name);
        exp_t e;
        sb.delete();
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == j) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.mask) !== e.val) begin
                    errors++;
                    $display("FAIL %s step %0d: got %h expected %h", name, j, obs & e.mask, e.val);
                end
            end
            hb = (j < 16) ? pat[j] : 1'b0;
            if (j < 16) sb.push_back('{j + 2, 12'h001, {11'b0, hb}});
        end
        hb = 1'b0;
    endtask

    task automatic test_divider();
        exp_t e;
        logic b;
        cfg(1, 0, 9);
        cfg(1, 1, 3);
        cfg(1, 2, 1);
        sb.delete();
        sb.push_back('{0, 12'h204, 12'h204});
        for (int j = 0; j < 41; j++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == j) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.mask) !== e.val) begin
                    errors++;
                    $display("FAIL divider step %0d: got %h expected %h", j, obs & e.mask, e.val);
                end
            end
            strobe = (j == 26);
            ch     = 2'd1;
            sel    = 2'd0;
            data   = 16'd2;
            b = (j + 1 <= 27) ? ((j + 1) % 10 < 3) : (j + 1 == 28) ? 1'b0 : 1'b1;
            sb.push_back('{j + 1, 12'h204, b ? 12'h204 : 12'h200});
        end
        strobe = 1'b0;
    endtask

    task automatic test_oneshot();
        exp_t e;
        int last;
        cfg(2, 1, 5);
        cfg(2, 2, 3);
        sb.delete();
        last = -100;
        for (int j = 0; j < 26; j++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == j) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.mask) !== e.val) begin
                    errors++;
                    $display("FAIL oneshot step %0d: got %h expected %h", j, obs & e.mask, e.val);
                end
            end
            hb = (j == 2 || j == 6);
            if (hb) last = j;
            sb.push_back('{j + 2, 12'h409, ((j - last >= 0 && j - last <= 4) ? 12'h408 : 12'h000) | {11'b0, hb}});
        end
        hb = 1'b0;
        cfg(2, 1, 0);
        sb.delete();
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == j) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.mask) !== e.val) begin
                    errors++;
                    $display("FAIL oneshot_high0 step %0d: got %h expected %h", j, obs & e.mask, e.val);
                end
            end
            hb = (j == 1);
            sb.push_back('{j + 2, 12'h009, {11'b0, hb}});
        end
        hb = 1'b0;
    endtask

    task automatic test_resync();
        exp_t e;
        int p;
        int r;
        cfg(0, 2, 9);
        p = -1;
        for (int j = 0; j < 1300 && p < 0; j++) begin
            @(negedge clk);
            if (bus[1]) p = j;
        end
        checks++;
        if (p < 0) begin
            errors++;
            $display("FAIL resync_ping_wait: got none expected a ping within 1300 cycles");
            return;
        end
        sb.delete();
        for (int m = 1; m < 1856; m++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == m) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.mask) !== e.val) begin
                    errors++;
                    $display("FAIL resync step %0d: got %h expected %h", m, obs & e.mask, e.val);
                end
            end
            hb     = (m == 599);
            strobe = (m == 599);
            ch     = 2'd0;
            sel    = 2'd1;
            data   = 16'd2;
            if (m == 599) begin
                for (int s = 600; s < 1854; s++) begin
                    r = s - 601;
                    sb.push_back('{s, 12'h003, ((s != 600 && (r % 1250) < 2) ? 12'h002 : 12'h000) | ((s == 601) ? 12'h001 : 12'h000)});
                end
            end
        end
        hb     = 1'b0;
        strobe = 1'b0;
    endtask

    task automatic test_passthrough();
        exp_t e;
        cfg(3, 2, 5);
        sb.delete();
        for (int j = 0; j < 31; j++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == j) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.mask) !== e.val) begin
                    errors++;
                    $display("FAIL passthrough step %0d: got %h expected %h", j, obs & e.mask, e.val);
                end
            end
            ext = 4'($urandom_range(0, 15));
            if (j < 30) sb.push_back('{j + 1, 12'h810, 12'h800 | (ext[3] ? 12'h010 : 12'h000)});
        end
        ext = 4'hf;
        cfg(3, 2, 7);
        repeat (2) @(negedge clk);
        checks++;
        if ((obs & 12'h810) !== 12'h000) begin
            errors++;
            $display("FAIL mode3: got %h expected 000", obs & 12'h810);
        end
        cfg(3, 2, 4);
        repeat (2) @(negedge clk);
        checks++;
        if ((obs & 12'h810) !== 12'h000) begin
            errors++;
            $display("FAIL disabled: got %h expected 000", obs & 12'h810);
        end
    endtask

    task automatic test_reset_mid_pulse();
        exp_t e;
        cfg(2, 1, 5);
        hb = 1'b1;
        @(negedge clk);
        hb = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus[3] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pulse_high: got %b expected 1", bus[3]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: got %h expected 000", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        for (int j = 0; j < 6; j++) sb.push_back('{j, 12'hfff, (j == 0) ? 12'h102 : 12'h100});
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == j) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.mask) !== e.val) begin
                    errors++;
                    $display("FAIL reset_release step %0d: got %h expected %h", j, obs & e.mask, e.val);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat(16'h0001, "hb_single");
        test_heartbeat(16'h0003, "hb_back_to_back");
        test_divider();
        test_oneshot();
        test_resync();
        test_passthrough();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
